simon_data_out: RTL and testbench

- Output packetiser for the SIMON cipher core.
- Collects two successive 2-word cipher result blocks from the datapath through a doneDATA/readDATA handshake.
- Prepends an info byte and a packet-count byte, and presents the whole packet as a byte array to the output interface.
- Signals packet-ready with out_donePKT and releases the buffer when the consumer acknowledges with out_readPKT.

---
 rtl/simon_data_out_pkg.sv | 26 ++
 rtl/simon_data_out_if.sv | 25 ++
 rtl/simon_data_out.sv | 104 ++++++++++
 tb/tb_simon_data_out.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/simon_data_out_pkg.sv
// Shared constants and types for the SIMON output packetiser.
// Packet layout: info byte, count byte, then two blocks of two little-endian words.
package simon_data_out_pkg;

   localparam int N     = 16;
   localparam int WB    = N / 8;
   localparam int BB    = 2 * WB;
   localparam int PKT   = 2 + N / 2;

   localparam int INFO  = 0;
   localparam int COUNT = 1;
   localparam int DATA0 = 2;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_e;

   typedef logic [1:0][N-1:0]   block_t;
   typedef logic [PKT-1:0][7:0] pkt_t;

   function automatic int byte_offset(input int blk, input int w, input int k);
      return DATA0 + blk * BB + w * WB + k;
   endfunction

endpackage

// File: rtl/simon_data_out_if.sv
// Handshake bundle between the SIMON datapath, the packetiser and the packet consumer.
// master = producer/consumer side, slave = the packetiser.
interface simon_data_out_if;
   import simon_data_out_pkg::*;

   logic   doneDATA;
   block_t outDATA;
   logic   [7:0] infoOUT;
   logic   [7:0] countOUT;
   logic   out_readPKT;
   logic   readDATA;
   logic   out_donePKT;
   pkt_t   out;

   modport master (
      output doneDATA, outDATA, infoOUT, countOUT, out_readPKT,
      input  readDATA, out_donePKT, out
   );

   modport slave (
      input  doneDATA, outDATA, infoOUT, countOUT, out_readPKT,
      output readDATA, out_donePKT, out
   );

endinterface

// File: rtl/simon_data_out.sv
// Collects two cipher blocks, prepends info/count bytes and holds the packet
// until the consumer acknowledges it.
module simon_data_out
   import simon_data_out_pkg::*;
(
   input  logic             clk,
   input  logic             nR,
   simon_data_out_if.slave  bus
);

   state_e state_q, state_d;
   logic   blk_q, blk_d;
   logic   armed_q, armed_d;
   logic   read_q, read_d;
   pkt_t   pkt_q, pkt_d;

   logic   capture;
   logic   done_pkt;
   logic   [2*BB-1:0][7:0] data_d;
   logic   [7:0] info_d;
   logic   [7:0] count_d;

   // A block is taken only once per doneDATA assertion and never while the packet waits.
   assign capture = (state_q == FILL) && bus.doneDATA && armed_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (nR) begin
         state_q <= FILL;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FILL: if (capture && blk_q) state_d = FULL;
         FULL: if (bus.out_readPKT)  state_d = FILL;
         default: state_d = FILL;
      endcase
   end

   always_comb begin
      done_pkt = (state_q == FULL);
   end

   always_comb begin
      blk_d   = capture ? ~blk_q : blk_q;
      read_d  = capture;
      armed_d = armed_q;
      if (!bus.doneDATA) begin
         armed_d = 1'b1;
      end else if (capture) begin
         armed_d = 1'b0;
      end
   end

   // Each payload byte slot keeps its value unless its block is the one being captured.
   for (genvar b = 0; b < 2; b++) begin : g_blk
      localparam logic BLK = 1'(b);
      for (genvar w = 0; w < 2; w++) begin : g_word
         for (genvar k = 0; k < WB; k++) begin : g_byte
            localparam int IDX = byte_offset(b, w, k);
            assign data_d[IDX-DATA0] = (capture && (blk_q == BLK))
                                     ? bus.outDATA[w][8*k +: 8]
                                     : pkt_q[IDX];
         end
      end
   end

   // Header bytes are latched together with the completing block.
   always_comb begin
      info_d  = pkt_q[INFO];
      count_d = pkt_q[COUNT];
      if (capture && blk_q) begin
         info_d  = bus.infoOUT;
         count_d = bus.countOUT;
      end
      pkt_d = {data_d, count_d, info_d};
   end

   // NOTE: the packet buffer is reset along with the control flops because a
   // reset must present an all-zero packet, not just abort the partial one.
   always_ff @(posedge clk) begin
      if (nR) begin
         blk_q   <= 1'b0;
         armed_q <= 1'b1;
         read_q  <= 1'b0;
         pkt_q   <= '0;
      end else begin
         blk_q   <= blk_d;
         armed_q <= armed_d;
         read_q  <= read_d;
         pkt_q   <= pkt_d;
      end
   end

   assign bus.readDATA    = read_q;
   assign bus.out_donePKT = done_pkt;
   assign bus.out         = pkt_q;

endmodule

// File: tb/tb_simon_data_out.sv
// Directed bench for the SIMON output packetiser (N=16, 10-byte packets).
module tb_simon_data_out;
   import simon_data_out_pkg::*;

   logic clk;
   logic nR;
   int   compared;
   int   mismatched;
   int   pulses;

   simon_data_out_if bus ();

   simon_data_out u_dut (
      .clk (clk),
      .nR  (nR),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      nR               = 1'b1;
      bus.doneDATA     = 1'b1;
      bus.outDATA      = {16'h6565, 16'h6877};
      bus.infoOUT      = 8'hA5;
      bus.countOUT     = 8'h00;
      bus.out_readPKT  = 1'b0;

      // Reset held two cycles with doneDATA high
      tick(); tick();
      check("rst_out",  bus.out,         80'h0);
      check("rst_read", 80'(bus.readDATA),    80'h0);
      check("rst_done", 80'(bus.out_donePKT), 80'h0);

      // Capture on the first edge after release
      nR = 1'b0;
      tick();
      check("blk0_read", 80'(bus.readDATA),    80'h1);
      check("blk0_done", 80'(bus.out_donePKT), 80'h0);

      // doneDATA held for 5 cycles total: no further pulses
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.readDATA) pulses++;
      end
      check("held_pulses", 80'(pulses), 80'h0);

      bus.doneDATA = 1'b0;
      tick();
      check("rearm_read", 80'(bus.readDATA), 80'h0);

      // Second block completes packet 0
      bus.outDATA  = {16'hC69B, 16'hE9BB};
      bus.doneDATA = 1'b1;
      tick();
      check("pkt0_read", 80'(bus.readDATA),    80'h1);
      check("pkt0_done", 80'(bus.out_donePKT), 80'h1);
      check("pkt0_out",  bus.out, 80'hC69BE9BB6565687700A5);

      // Back-pressure: FULL ignores doneDATA, even when re-armed
      bus.outDATA = {16'h1111, 16'h2222};
      tick();
      check("bp_read0", 80'(bus.readDATA),    80'h0);
      check("bp_done0", 80'(bus.out_donePKT), 80'h1);
      bus.doneDATA = 1'b0;
      tick();
      bus.doneDATA = 1'b1;
      tick();
      check("bp_read1", 80'(bus.readDATA),    80'h0);
      check("bp_done1", 80'(bus.out_donePKT), 80'h1);
      check("bp_out",   bus.out, 80'hC69BE9BB6565687700A5);

      // Acknowledge with armed doneDATA on the same edge: only the ack is taken
      bus.out_readPKT = 1'b1;
      tick();
      check("ack_done", 80'(bus.out_donePKT), 80'h0);
      check("ack_read", 80'(bus.readDATA),    80'h0);
      check("ack_out",  bus.out, 80'hC69BE9BB6565687700A5);

      // Ack still high in FILL is harmless; capture lands in bytes 2..5
      bus.countOUT = 8'h01;
      tick();
      bus.out_readPKT = 1'b0;
      check("p1b0_read", 80'(bus.readDATA),    80'h1);
      check("p1b0_done", 80'(bus.out_donePKT), 80'h0);
      check("p1b0_out",  bus.out, 80'hC69BE9BB1111222200A5);

      bus.doneDATA = 1'b0;
      tick();
      bus.outDATA  = {16'h3333, 16'h4444};
      bus.doneDATA = 1'b1;
      tick();
      check("pkt1_read", 80'(bus.readDATA),    80'h1);
      check("pkt1_done", 80'(bus.out_donePKT), 80'h1);
      check("pkt1_out",  bus.out, 80'h333344441111222201A5);

      // Packet 2 with new header
      bus.doneDATA    = 1'b0;
      bus.out_readPKT = 1'b1;
      tick();
      bus.out_readPKT = 1'b0;
      check("ack1_done", 80'(bus.out_donePKT), 80'h0);
      bus.countOUT = 8'h02;
      bus.infoOUT  = 8'h3C;
      bus.outDATA  = {16'hABCD, 16'h0123};
      bus.doneDATA = 1'b1;
      tick();
      check("p2b0_out", bus.out, 80'h33334444ABCD012301A5);
      bus.doneDATA = 1'b0;
      tick();
      check("p2_gap_read", 80'(bus.readDATA), 80'h0);
      bus.outDATA  = {16'hDEAD, 16'hBEEF};
      bus.doneDATA = 1'b1;
      tick();
      check("pkt2_done", 80'(bus.out_donePKT), 80'h1);
      check("pkt2_out",  bus.out, 80'hDEADBEEFABCD0123023C);

      // Mid-packet reset
      bus.doneDATA    = 1'b0;
      bus.out_readPKT = 1'b1;
      tick();
      bus.out_readPKT = 1'b0;
      bus.outDATA  = {16'h5555, 16'h6666};
      bus.doneDATA = 1'b1;
      tick();
      check("mid_b0_read", 80'(bus.readDATA), 80'h1);
      nR = 1'b1;
      bus.doneDATA = 1'b0;
      tick();
      check("mid_rst_out",  bus.out, 80'h0);
      check("mid_rst_read", 80'(bus.readDATA),    80'h0);
      check("mid_rst_done", 80'(bus.out_donePKT), 80'h0);

      nR = 1'b0;
      bus.outDATA  = {16'h7777, 16'h8888};
      bus.doneDATA = 1'b1;
      tick();
      check("fresh_b0_read", 80'(bus.readDATA),    80'h1);
      check("fresh_b0_done", 80'(bus.out_donePKT), 80'h0);
      check("fresh_b0_out",  bus.out, 80'h00000000777788880000);
      bus.doneDATA = 1'b0;
      tick();
      bus.countOUT = 8'h07;
      bus.infoOUT  = 8'h11;
      bus.outDATA  = {16'h9999, 16'hAAAA};
      bus.doneDATA = 1'b1;
      tick();
      check("fresh_done", 80'(bus.out_donePKT), 80'h1);
      check("fresh_out",  bus.out, 80'h9999AAAA777788880711);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
